// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser.
//
// Contents: default frame-start marker, FSM state type and encodings,
// known opcode values, and the frame checksum helper.
//
// Build option: define UART_CMD_PARSER_CHECKSUM_EN to add the trailing
// checksum byte to every frame (and with it the CHK state). Without the
// macro a frame ends at ARG2.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [7:0] OP_PIXEL = 8'h01;
  localparam logic [7:0] OP_CLEAR = 8'h02;
  localparam logic [7:0] OP_MODE  = 8'h03;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_OP   = 3'd1;
  localparam state_t ST_A0   = 3'd2;
  localparam state_t ST_A1   = 3'd3;
  localparam state_t ST_A2   = 3'd4;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
  localparam state_t ST_CHK  = 3'd5;
`endif

  // XOR of the four payload bytes; the sender appends this as the last byte.
  function automatic logic [7:0] frame_chk(input logic [7:0] op,
                                           input logic [7:0] a0,
                                           input logic [7:0] a1,
                                           input logic [7:0] a2);
    return op ^ a0 ^ a1 ^ a2;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream in / command out bundle of the UART command parser.
//
// Signals:
//   byte_data, data_valid : received byte and its one-cycle strobe
//   cmd_valid, cmd_ready  : pending-command handshake
//   cmd_op, cmd_arg       : decoded opcode and {ARG0, ARG1, ARG2}
//   err_chk, err_timeout  : one-cycle error pulses
//   err_overflow          : sticky dropped-frame flag
// Modports: master = byte source / command consumer, slave = parser.
interface uart_cmd_parser_if;

  logic [7:0]  byte_data;
  logic        data_valid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [23:0] cmd_arg;
  logic        err_chk;
  logic        err_timeout;
  logic        err_overflow;

  modport master (
    output byte_data, data_valid, cmd_ready,
    input  cmd_valid, cmd_op, cmd_arg, err_chk, err_timeout, err_overflow
  );

  modport slave (
    input  byte_data, data_valid, cmd_ready,
    output cmd_valid, cmd_op, cmd_arg, err_chk, err_timeout, err_overflow
  );

endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter for the UART command parser.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   active_i   : parser is inside a frame (not IDLE)
//   clear_i    : a byte was received this cycle
//   expire_o   : combinational, high in the cycle the frame must be abandoned
//
// The counter holds zero while idle or when a byte arrives, so a byte in
// the would-be expiry cycle always wins over the timeout.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d  = count_q;
    expire_o = 1'b0;
    if (clear_i || !active_i) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      expire_o = 1'b1;
      count_d  = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command frame parser.
//
// Collects SYNC, OP, ARG0, ARG1, ARG2 [, CHK] from a byte stream and presents
// the decoded command on a valid/ready output that holds until accepted.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : uart_cmd_parser_if.slave (byte input, command output, error flags)
//
// Parameters: TIMEOUT_CYCLES (idle clocks before a partial frame is
// abandoned), SYNC_BYTE (frame start marker, only recognised in IDLE).
//
// Build option: UART_CMD_PARSER_CHECKSUM_EN enables the trailing checksum
// byte and err_chk; otherwise ARG2 ends the frame and err_chk stays 0.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  uart_cmd_parser_if.slave bus
);

  state_t      state_q, state_d;
  logic [7:0]  op_q, a0_q, a1_q;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
  logic [7:0]  a2_q;
  logic        chk_bad;
  logic        err_chk_q;
`endif
  logic        frame_done;
  logic [23:0] new_arg;
  logic        timeout_hit;

  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_op_q, cmd_op_d;
  logic [23:0] cmd_arg_q, cmd_arg_d;
  logic        err_timeout_q;
  logic        err_overflow_q, err_overflow_d;

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .active_i (state_q != ST_IDLE),
    .clear_i  (bus.data_valid),
    .expire_o (timeout_hit)
  );

  // Frame sequencing. A SYNC value seen after IDLE is plain payload.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
    chk_bad    = 1'b0;
`endif
    if (bus.data_valid) begin
      case (state_q)
        ST_IDLE: if (bus.byte_data == SYNC_BYTE) state_d = ST_OP;
        ST_OP:   state_d = ST_A0;
        ST_A0:   state_d = ST_A1;
        ST_A1:   state_d = ST_A2;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        ST_A2:   state_d = ST_CHK;
        ST_CHK: begin
          state_d = ST_IDLE;
          if (bus.byte_data == frame_chk(op_q, a0_q, a1_q, a2_q)) begin
            frame_done = 1'b1;
          end else begin
            chk_bad = 1'b1;
          end
        end
`else
        ST_A2: begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
    end
  end

`ifdef UART_CMD_PARSER_CHECKSUM_EN
  assign new_arg = {a0_q, a1_q, a2_q};
`else
  assign new_arg = {a0_q, a1_q, bus.byte_data};
`endif

  // A finished frame is taken if the slot is free or being emptied this
  // very cycle; otherwise it is lost and the overflow flag latches.
  always_comb begin
    cmd_valid_d    = cmd_valid_q;
    cmd_op_d       = cmd_op_q;
    cmd_arg_d      = cmd_arg_q;
    err_overflow_d = err_overflow_q;
    if (frame_done && (!cmd_valid_q || bus.cmd_ready)) begin
      cmd_valid_d = 1'b1;
      cmd_op_d    = op_q;
      cmd_arg_d   = new_arg;
    end else begin
      if (frame_done) err_overflow_d = 1'b1;
      if (cmd_valid_q && bus.cmd_ready) cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cmd_valid_q    <= 1'b0;
      cmd_op_q       <= '0;
      cmd_arg_q      <= '0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_op_q       <= cmd_op_d;
      cmd_arg_q      <= cmd_arg_d;
      err_timeout_q  <= timeout_hit;
      err_overflow_q <= err_overflow_d;
    end
  end

  // Payload capture; contents are only consumed once the frame completes,
  // so no reset is needed here.
  always_ff @(posedge clk) begin
    if (bus.data_valid) begin
      case (state_q)
        ST_OP: op_q <= bus.byte_data;
        ST_A0: a0_q <= bus.byte_data;
        ST_A1: a1_q <= bus.byte_data;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        ST_A2: a2_q <= bus.byte_data;
`endif
        default: ;
      endcase
    end
  end

`ifdef UART_CMD_PARSER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_chk_q <= 1'b0;
    end else begin
      err_chk_q <= chk_bad;
    end
  end
  assign bus.err_chk = err_chk_q;
`else
  assign bus.err_chk = 1'b0;
`endif

  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.cmd_op       = cmd_op_q;
  assign bus.cmd_arg      = cmd_arg_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.err_overflow = err_overflow_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a frame-level model in the driver
// predicts commands and error pulses with the cycle they should appear; a
// separate monitor compares DUT outputs against those predictions.
module tb_uart_cmd_parser;

  localparam int TO = 16;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
  localparam int NB = 5;   // bytes after SYNC
  localparam bit CHK_EN = 1'b1;
`else
  localparam int NB = 4;
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  op;
    logic [23:0] arg;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(
    .TIMEOUT_CYCLES(TO),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectations
  exp_t exp_cmd[$];
  int   exp_chk[$];
  int   exp_to[$];
  bit   ovf_exp = 1'b0;
  int   ovf_at = 0;

  // Model state: frame bytes collected so far, idle clock count in frame.
  bit         m_in = 1'b0;
  logic [7:0] m_frame[$];
  int         m_idle = 0;
  bit         m_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model(input bit dv, input logic [7:0] b, input bit rdy, input int e);
    bit         hs;
    bit         done;
    bit         good;
    logic [7:0] x;
    exp_t       n;
    hs   = m_vld && rdy;
    done = 1'b0;
    if (dv) begin
      if (!m_in) begin
        if (b == 8'hA5) begin
          m_in = 1'b1;
          m_frame.delete();
        end
      end else begin
        m_frame.push_back(b);
        if (m_frame.size() == NB) begin
          m_in = 1'b0;
          x = m_frame[0] ^ m_frame[1] ^ m_frame[2] ^ m_frame[3];
`ifdef UART_CMD_PARSER_CHECKSUM_EN
          good = (x == m_frame[4]);
`else
          good = 1'b1;
          x = 8'h00;
`endif
          if (good) done = 1'b1;
          else exp_chk.push_back(e);
        end
      end
      m_idle = 0;
    end else if (m_in) begin
      m_idle++;
      if (m_idle == TO) begin
        m_in = 1'b0;
        exp_to.push_back(e);
      end
    end
    if (done) begin
      if (!m_vld || rdy) begin
        n.op  = m_frame[0];
        n.arg = {m_frame[1], m_frame[2], m_frame[3]};
        n.at  = e;
        exp_cmd.push_back(n);
        m_vld = 1'b1;
      end else if (!ovf_exp) begin
        ovf_exp = 1'b1;
        ovf_at  = e;
      end
    end else if (hs) begin
      m_vld = 1'b0;
    end
  endtask

  // One clock of stimulus; the model predicts the state after the next edge.
  task automatic step(input bit dv, input logic [7:0] b, input bit rdy);
    @(posedge clk);
    #1;
    bus.data_valid = dv;
    bus.byte_data  = dv ? b : 8'($urandom);
    bus.cmd_ready  = rdy;
    model(dv, b, rdy, cyc + 1);
  endtask

  function automatic bit pick(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic idle(input int n, input int pct);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, pick(pct));
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input int gap_max, input int pct);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) idle($urandom_range(0, gap_max), pct);
      step(1'b1, q[i], pick(pct));
    end
  endtask

  function automatic void build(output logic [7:0] q[$], input logic [7:0] op,
                                input logic [7:0] a0, input logic [7:0] a1,
                                input logic [7:0] a2, input bit corrupt);
    q.delete();
    q.push_back(8'hA5);
    q.push_back(op);
    q.push_back(a0);
    q.push_back(a1);
    q.push_back(a2);
    if (CHK_EN) q.push_back(op ^ a0 ^ a1 ^ a2 ^ (corrupt ? 8'h10 : 8'h00));
  endfunction

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a0,
                            input logic [7:0] a1, input logic [7:0] a2,
                            input bit corrupt, input int gap_max, input int pct);
    logic [7:0] q[$];
    build(q, op, a0, a1, a2, corrupt);
    send_bytes(q, gap_max, pct);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.data_valid = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.byte_data  = 8'h00;
    #2;
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_cmd_op", bus.cmd_op, 0);
    check("rst_cmd_arg", bus.cmd_arg, 0);
    check("rst_err_chk", bus.err_chk, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    check("rst_err_overflow", bus.err_overflow, 0);
    m_in = 1'b0;
    m_vld = 1'b0;
    m_idle = 0;
    m_frame.delete();
    exp_cmd.delete();
    exp_chk.delete();
    exp_to.delete();
    ovf_exp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor
  exp_t cur;
  bit   prev_vld = 1'b0;
  bit   prev_hs = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (bus.cmd_valid) begin
        if (!prev_vld || prev_hs) begin
          if (exp_cmd.size() == 0) begin
            check("spurious_cmd_valid", 1, 0);
          end else begin
            cur = exp_cmd.pop_front();
            check("cmd_valid_cycle", cyc, cur.at);
            check("cmd_op", bus.cmd_op, cur.op);
            check("cmd_arg", bus.cmd_arg, cur.arg);
          end
        end else begin
          check("cmd_op_hold", bus.cmd_op, cur.op);
          check("cmd_arg_hold", bus.cmd_arg, cur.arg);
        end
      end
      if (exp_cmd.size() > 0 && exp_cmd[0].at < cyc) begin
        check("cmd_missing", 0, exp_cmd[0].at);
        void'(exp_cmd.pop_front());
      end
      if (bus.err_chk) begin
        if (exp_chk.size() == 0) check("spurious_err_chk", 1, 0);
        else check("err_chk_cycle", cyc, exp_chk.pop_front());
      end
      if (exp_chk.size() > 0 && exp_chk[0] < cyc) begin
        check("err_chk_missing", 0, exp_chk[0]);
        void'(exp_chk.pop_front());
      end
      if (bus.err_timeout) begin
        if (exp_to.size() == 0) check("spurious_err_timeout", 1, 0);
        else check("err_timeout_cycle", cyc, exp_to.pop_front());
      end
      if (exp_to.size() > 0 && exp_to[0] < cyc) begin
        check("err_timeout_missing", 0, exp_to[0]);
        void'(exp_to.pop_front());
      end
      check("err_overflow", bus.err_overflow, 32'(ovf_exp && cyc >= ovf_at));
      prev_vld = bus.cmd_valid;
      prev_hs  = bus.cmd_valid && bus.cmd_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    bus.data_valid = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.byte_data  = 8'h00;
    do_reset();
    idle(2, 100);

    // Basic decode, always ready.
    send_frame(8'h01, 8'h12, 8'h34, 8'h56, 1'b0, 0, 100);
    idle(4, 100);
    // Corrupted checksum.
    send_frame(8'h01, 8'h12, 8'h34, 8'h56, 1'b1, 0, 100);
    idle(4, 100);
    // Garbage in IDLE, then a good frame.
    q.delete();
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'hA4);
    send_bytes(q, 1, 100);
    send_frame(8'h03, 8'hAA, 8'hBB, 8'hCC, 1'b0, 1, 100);
    idle(4, 100);
    // Partial frame abandoned by timeout, then a clean frame.
    q.delete();
    q.push_back(8'hA5);
    q.push_back(8'h01);
    send_bytes(q, 0, 100);
    idle(TO + 4, 100);
    send_frame(8'h02, 8'h01, 8'h02, 8'h03, 1'b0, 0, 100);
    idle(4, 100);
    // Byte arriving exactly on the last allowed idle clock is consumed.
    q.delete();
    q.push_back(8'hA5);
    q.push_back(8'h03);
    send_bytes(q, 0, 100);
    idle(TO - 1, 100);
    q.delete();
    q.push_back(8'h11);
    q.push_back(8'h22);
    q.push_back(8'h33);
    if (CHK_EN) q.push_back(8'h03 ^ 8'h11 ^ 8'h22 ^ 8'h33);
    send_bytes(q, 0, 100);
    idle(4, 100);
    // SYNC value used as payload.
    send_frame(8'hA5, 8'hA5, 8'h00, 8'hA5, 1'b0, 0, 100);
    idle(4, 100);
    // Consumer stalled: first held, second dropped, overflow sticks.
    send_frame(8'h01, 8'h10, 8'h20, 8'h30, 1'b0, 0, 0);
    send_frame(8'h02, 8'h40, 8'h50, 8'h60, 1'b0, 0, 0);
    idle(6, 0);
    idle(6, 100);
    // Frame completing in the same cycle the pending command is taken.
    send_frame(8'h03, 8'h01, 8'h01, 8'h01, 1'b0, 0, 0);
    build(q, 8'h01, 8'h77, 8'h88, 8'h99, 1'b0);
    for (int i = 0; i < q.size(); i++) step(1'b1, q[i], i == q.size() - 1);
    idle(3, 0);
    idle(3, 100);
    // Reset mid-frame, then a fresh frame.
    q.delete();
    q.push_back(8'hA5);
    q.push_back(8'h01);
    q.push_back(8'h12);
    send_bytes(q, 0, 100);
    do_reset();
    send_frame(8'h02, 8'h00, 8'h00, 8'h00, 1'b0, 0, 100);
    idle(4, 100);

    // Randomised traffic.
    for (int n = 0; n < 200; n++) begin
      int kind;
      int pct;
      kind = $urandom_range(0, 9);
      pct  = $urandom_range(20, 100);
      if (kind <= 5) begin
        send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   $urandom_range(0, 5) == 0, 3, pct);
      end else if (kind <= 7) begin
        q.delete();
        for (int i = 0; i < $urandom_range(1, 4); i++) q.push_back(8'($urandom));
        send_bytes(q, 2, pct);
      end else if (kind == 8) begin
        q.delete();
        q.push_back(8'hA5);
        for (int i = 0; i < $urandom_range(0, NB - 1); i++) q.push_back(8'($urandom));
        send_bytes(q, 2, pct);
        idle($urandom_range(TO - 2, TO + 3), pct);
      end else begin
        idle($urandom_range(1, 6), pct);
      end
    end

    idle(30, 100);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("chk_queue_drained", exp_chk.size(), 0);
    check("timeout_queue_drained", exp_to.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
